// File: rtl/apb_master_xactor.sv
// apb_master_xactor
//
// Single-outstanding APB3 master for the engine register bus (rbus). A simple
// valid/ready command interface is turned into an APB setup phase followed by
// an access phase; the outcome comes back as a one-cycle response pulse.
// A slave error (pslverr) or an access phase that waits too long for pready
// is reported as an error.
//
// Ports
//   clk, reset_n        clock (rising edge) and synchronous active-low reset
//   cmd_valid/ready     command handshake; accepted only when idle
//   cmd_write           1 = write, 0 = read
//   cmd_addr/cmd_wdata  target address and write data
//   rsp_valid           one-cycle response pulse
//   rsp_rdata           read data (0 for writes and timeouts)
//   rsp_error           slave error or timeout
//   rsp_timeout         the error was caused by the pready timeout
//   psel/penable/paddr/pwdata/pwrite   APB request outputs (registered)
//   prdata/pready/pslverr              APB completion inputs
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | cmd_ready high, APB bus driven to zero, waiting for a command
// SETUP  | APB setup phase: psel=1, penable=0 (always exactly one cycle)
// ACCESS | APB access phase: psel=penable=1, waiting for pready or timeout
// RESP   | rsp_valid pulse, APB bus back to zero

module apb_master_xactor #(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,

    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  psel,
    output logic                  penable,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite
);

    // The counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end

                ACCESS: begin
                    // pready is checked first so a completion in the last
                    // allowed cycle is a normal response, not a timeout.
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_error   <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        paddr       <= '0;
                        pwdata      <= '0;
                        state       <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_rdata   <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        paddr       <= '0;
                        pwdata      <= '0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    cmd_ready <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_xactor.sv
module tb_apb_master_xactor;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          psel;
    logic          penable;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of the most recent run_xact call
    int          o_lat;
    logic [DW-1:0] o_rdata;
    logic        o_err;
    logic        o_to;
    int          o_npsel;
    int          o_npen;
    int          o_badbus;
    int          o_badready;
    bit          o_post_ok;
    logic        o_ready_before;

    apb_master_xactor #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .psel       (psel),
        .penable    (penable),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite)
    );

    always #5 clk = ~clk;

    // Reference model: what the requester should see for one transaction
    // whose slave answers after 'waits' wait states (never = no pready).
    function automatic bit m_timed_out(input int waits, input bit never);
        return never || (waits >= TO);
    endfunction

    function automatic int m_latency(input int waits, input bit never);
        return m_timed_out(waits, never) ? (TO + 2) : (waits + 3);
    endfunction

    function automatic logic [DW-1:0] m_rdata(input bit wr, input int waits,
                                             input bit never, input logic [DW-1:0] rd);
        if (m_timed_out(waits, never) || wr) return '0;
        return rd;
    endfunction

    function automatic bit m_error(input int waits, input bit never, input bit err);
        return m_timed_out(waits, never) || err;
    endfunction

    // Drives one command from a negedge, plays the APB slave, and records
    // what it saw. Returns at a negedge one cycle after the response.
    task automatic run_xact(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int waits, input bit never, input bit err,
                            input logic [DW-1:0] rd);
        logic [DW-1:0] held;
        o_lat = -1; o_rdata = 'x; o_err = 1'bx; o_to = 1'bx;
        o_npsel = 0; o_npen = 0; o_badbus = 0; o_badready = 0; o_post_ok = 0;
        o_ready_before = cmd_ready;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        cmd_write = $urandom_range(0, 1);
        for (int c = 1; c <= 40; c++) begin
            if (cmd_ready !== 1'b0) o_badready++;
            if (rsp_valid === 1'b1) begin
                o_lat = c; o_rdata = rsp_rdata; o_err = rsp_error; o_to = rsp_timeout;
                if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0 ||
                    paddr !== '0 || pwdata !== '0) o_badbus++;
                break;
            end
            if (psel === 1'b1) begin
                o_npsel++;
                if (paddr !== a || pwrite !== wr || pwdata !== (wr ? wd : '0)) o_badbus++;
            end
            if (penable === 1'b1) begin
                o_npen++;
                if (psel !== 1'b1) o_badbus++;
            end
            if (psel === 1'b1 && penable === 1'b1) begin
                if (!never && (o_npen - 1) == waits) begin
                    pready = 1'b1; prdata = rd; pslverr = err;
                end else begin
                    pready = 1'b0; prdata = $urandom; pslverr = $urandom_range(0, 1);
                end
            end else begin
                pready = $urandom_range(0, 1); prdata = $urandom; pslverr = $urandom_range(0, 1);
            end
            @(negedge clk);
        end
        pready = 1'b0; pslverr = 1'b0;
        held = rsp_rdata;
        @(negedge clk);
        o_post_ok = (rsp_valid === 1'b0) && (cmd_ready === 1'b1) && (psel === 1'b0) &&
                    (rsp_rdata === held);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({psel, penable, pwrite} !== 3'b000 || paddr !== '0 || pwdata !== '0)
            $display("FAIL reset_bus: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h required all 0",
                     psel, penable, pwrite, paddr, pwdata);
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b000 || rsp_rdata !== '0)
            $display("FAIL reset_rsp: valid=%b err=%b to=%b rdata=%h required all 0",
                     rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL reset_idle: cmd_ready=%b psel=%b rsp_valid=%b required 1 0 0",
                     cmd_ready, psel, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_write();
        run_xact(1'b1, 20'h00010, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (o_lat !== 3) $display("FAIL wr_latency: got %0d required 3", o_lat); else n_pass++;
        n_checks++;
        if (o_npsel !== 2 || o_npen !== 1)
            $display("FAIL wr_phases: psel %0d penable %0d cycles required 2 1", o_npsel, o_npen);
        else n_pass++;
        n_checks++;
        if (o_badbus !== 0) $display("FAIL wr_bus: %0d bad bus cycles required 0", o_badbus); else n_pass++;
        n_checks++;
        if (o_err !== 1'b0 || o_to !== 1'b0 || o_rdata !== '0)
            $display("FAIL wr_rsp: err=%b to=%b rdata=%h required 0 0 0", o_err, o_to, o_rdata);
        else n_pass++;
        n_checks++;
        if (o_badready !== 0 || o_post_ok !== 1'b1)
            $display("FAIL wr_ready: busy-ready=%0d post_ok=%b required 0 1", o_badready, o_post_ok);
        else n_pass++;
    endtask

    task automatic test_read_wait();
        run_xact(1'b0, 20'h00020, 32'h0, 3, 1'b0, 1'b0, 32'h12345678);
        n_checks++;
        if (o_lat !== 6) $display("FAIL rd_latency: got %0d required 6", o_lat); else n_pass++;
        n_checks++;
        if (o_npen !== 4 || o_badbus !== 0)
            $display("FAIL rd_phases: penable %0d cycles bad bus %0d required 4 0", o_npen, o_badbus);
        else n_pass++;
        n_checks++;
        if (o_rdata !== 32'h12345678 || o_err !== 1'b0 || o_to !== 1'b0)
            $display("FAIL rd_rsp: rdata=%h err=%b to=%b required 12345678 0 0", o_rdata, o_err, o_to);
        else n_pass++;
    endtask

    task automatic test_slverr();
        run_xact(1'b0, 20'h00444, 32'h0, 1, 1'b0, 1'b1, 32'hA5A50F0F);
        n_checks++;
        if (o_err !== 1'b1 || o_to !== 1'b0 || o_rdata !== 32'hA5A50F0F)
            $display("FAIL slverr_rsp: err=%b to=%b rdata=%h required 1 0 a5a50f0f", o_err, o_to, o_rdata);
        else n_pass++;
        n_checks++;
        if (o_lat !== 4) $display("FAIL slverr_latency: got %0d required 4", o_lat); else n_pass++;
    endtask

    task automatic test_timeout();
        run_xact(1'b0, 20'h00777, 32'h0, 0, 1'b1, 1'b0, 32'hFFFFFFFF);
        n_checks++;
        if (o_npen !== TO) $display("FAIL to_access_len: got %0d required %0d", o_npen, TO); else n_pass++;
        n_checks++;
        if (o_lat !== TO + 2) $display("FAIL to_latency: got %0d required %0d", o_lat, TO + 2); else n_pass++;
        n_checks++;
        if (o_err !== 1'b1 || o_to !== 1'b1 || o_rdata !== '0)
            $display("FAIL to_rsp: err=%b to=%b rdata=%h required 1 1 0", o_err, o_to, o_rdata);
        else n_pass++;
        n_checks++;
        if (o_badbus !== 0 || o_post_ok !== 1'b1)
            $display("FAIL to_bus: bad bus %0d post_ok=%b required 0 1", o_badbus, o_post_ok);
        else n_pass++;
    endtask

    // pready arriving in the final allowed access cycle completes normally
    task automatic test_timeout_boundary();
        run_xact(1'b0, 20'h00888, 32'h0, TO - 1, 1'b0, 1'b0, 32'h0C0FFEE0);
        n_checks++;
        if (o_err !== 1'b0 || o_to !== 1'b0 || o_rdata !== 32'h0C0FFEE0 || o_lat !== TO + 2)
            $display("FAIL to_boundary: err=%b to=%b rdata=%h lat=%0d required 0 0 0c0ffee0 %0d",
                     o_err, o_to, o_rdata, o_lat, TO + 2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nacc = 0, acc1 = -1, acc2 = -1, r1 = -1, r2 = -1, viol = 0;
        logic [DW-1:0] rd1 = '1, rd2 = '0;
        bit a2ok = 0;
        pready = 1'b1; prdata = 32'h0BADF00D; pslverr = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00100; cmd_wdata = 32'h11112222;
        for (int c = 0; c < 16; c++) begin
            if (rsp_valid === 1'b1) begin
                if (r1 < 0) begin r1 = c; rd1 = rsp_rdata; end
                else if (r2 < 0) begin r2 = c; rd2 = rsp_rdata; end
            end
            if ((psel === 1'b1 || rsp_valid === 1'b1) && cmd_ready !== 1'b0) viol++;
            if (nacc == 2 && c == acc2 + 1)
                a2ok = (psel === 1'b1) && (penable === 1'b0) && (paddr === 20'h00200) && (pwrite === 1'b0);
            if (cmd_valid && cmd_ready === 1'b1) begin
                nacc++;
                if (nacc == 1) acc1 = c; else acc2 = c;
            end else begin
                if (nacc == 1) begin cmd_write = 1'b0; cmd_addr = 20'h00200; cmd_wdata = $urandom; end
                if (nacc >= 2) cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0; pready = 1'b0;
        n_checks++;
        if (acc1 !== 0 || acc2 !== 4)
            $display("FAIL b2b_accept: accepts at %0d,%0d required 0,4", acc1, acc2);
        else n_pass++;
        n_checks++;
        if (r1 !== 3 || r2 !== 7)
            $display("FAIL b2b_rsp_time: responses at %0d,%0d required 3,7", r1, r2);
        else n_pass++;
        n_checks++;
        if (rd1 !== '0 || rd2 !== 32'h0BADF00D)
            $display("FAIL b2b_rdata: got %h,%h required 0,0badf00d", rd1, rd2);
        else n_pass++;
        n_checks++;
        if (viol !== 0 || a2ok !== 1'b1)
            $display("FAIL b2b_ready: busy-ready cycles %0d second setup ok=%b required 0 1", viol, a2ok);
        else n_pass++;
    endtask

    task automatic test_random();
        bit wr, never, err;
        int waits;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        for (int i = 0; i < 24; i++) begin
            wr    = $urandom_range(0, 1);
            never = ($urandom_range(0, 5) == 0);
            err   = $urandom_range(0, 1);
            waits = $urandom_range(0, 9);
            a     = AW'($urandom);
            wd    = $urandom;
            rd    = $urandom;
            run_xact(wr, a, wd, waits, never, err, rd);
            n_checks++;
            if (o_lat !== m_latency(waits, never))
                $display("FAIL rnd%0d_latency: got %0d required %0d", i, o_lat, m_latency(waits, never));
            else n_pass++;
            n_checks++;
            if (o_rdata !== m_rdata(wr, waits, never, rd) || o_err !== m_error(waits, never, err) ||
                o_to !== m_timed_out(waits, never))
                $display("FAIL rnd%0d_rsp: rdata=%h err=%b to=%b required %h %b %b", i, o_rdata, o_err, o_to,
                         m_rdata(wr, waits, never, rd), m_error(waits, never, err), m_timed_out(waits, never));
            else n_pass++;
            n_checks++;
            if (o_npsel !== m_latency(waits, never) - 1 || o_npen !== m_latency(waits, never) - 2 ||
                o_badbus !== 0 || o_badready !== 0 || o_post_ok !== 1'b1 || o_ready_before !== 1'b1)
                $display("FAIL rnd%0d_bus: psel=%0d pen=%0d bad=%0d busyrdy=%0d post=%b pre=%b required %0d %0d 0 0 1 1",
                         i, o_npsel, o_npen, o_badbus, o_badready, o_post_ok, o_ready_before,
                         m_latency(waits, never) - 1, m_latency(waits, never) - 2);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        bit reached = 0;
        int spurious = 0;
        pready = 1'b0; pslverr = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00ABC; cmd_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (penable === 1'b1) begin reached = 1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (reached !== 1'b1) $display("FAIL midrst_access: access phase not seen, required seen"); else n_pass++;
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL midrst_abort: psel=%b penable=%b rsp_valid=%b cmd_ready=%b required 0 0 0 1",
                     psel, penable, rsp_valid, cmd_ready);
        else n_pass++;
        reset_n = 1'b1;
        pready = 1'b1; prdata = 32'h5555AAAA;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid !== 1'b0 || psel !== 1'b0) spurious++;
            @(negedge clk);
        end
        pready = 1'b0;
        n_checks++;
        if (spurious !== 0) $display("FAIL midrst_quiet: %0d active cycles required 0", spurious); else n_pass++;
        run_xact(1'b1, 20'h00DEF, 32'hCAFEF00D, 2, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (o_lat !== 5 || o_err !== 1'b0 || o_to !== 1'b0 || o_badbus !== 0)
            $display("FAIL midrst_recover: lat=%0d err=%b to=%b bad=%0d required 5 0 0 0",
                     o_lat, o_err, o_to, o_badbus);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/apb_master_xactor.md
Name: apb_master_xactor

Overview:
- Synthesizable single-outstanding APB3 master for the engine's register bus (rbus).
- Converts a simple command/response interface into APB setup/access phases.
- Reports an error if the slave asserts pslverr or the pready wait exceeds a timeout.
- Used to drive engine configuration: sequences of register reads (with compare done by the requester) and writes.

Parameters:
- ADDR_WIDTH, 20, APB address width (set to N_RBUS_ADDR_BITS at integration).
- DATA_WIDTH, 32, APB data width (set to N_RBUS_DATA_BITS).
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles without pready before abort; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_error  out  1  pslverr or timeout; 0 = success
- rsp_timeout  out  1  error cause was timeout
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pwrite  out  1  APB direction

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE; wait counter clears.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_error and rsp_timeout all go to 0.
  - cmd_ready=1 from the first cycle after reset.
  - Reset mid-transfer aborts it immediately: no rsp_valid is generated for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; APB outputs held at 0.
  - On cmd_valid&&cmd_ready: register write/addr/wdata, go to SETUP.
  - For reads, pwdata=0.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, paddr/pwrite/pwdata stable.
  - Go to ACCESS; clear the wait counter.
- ACCESS:
  - psel=1, penable=1, address/data/direction unchanged.
  - If pready=1: capture prdata (reads only, else 0) and pslverr into the response registers; go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with pready still 0, go to RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - pready and timeout in the same cycle: pready wins (normal completion).
- RESP (1 cycle):
  - psel=0, penable=0, paddr/pwdata/pwrite=0.
  - rsp_valid=1 with the registered rsp_* values; go to IDLE.
- cmd_ready=0 in SETUP, ACCESS and RESP. Commands are only accepted in IDLE; one outstanding transaction at a time.
- rsp_rdata/rsp_error/rsp_timeout are held stable until the next response.
- Minimum latency (accept at edge N, zero wait states):
  - SETUP during cycle N+1, ACCESS during N+2.
  - rsp_valid during N+3; next command accepted at N+4.
  - Back-to-back transfers therefore occur at most every 4 cycles.
- pslverr is only sampled when psel&penable&pready. pready/prdata are ignored outside ACCESS.

Test Plan:
- Write addr 0x00010, data 0xDEADBEEF, pready=1 in the ACCESS cycle:
  - psel 1 for 2 cycles, penable 1 for 1 cycle, pwrite=1, pwdata=0xDEADBEEF.
  - rsp_valid 3 cycles after accept, rsp_error=0, rsp_rdata=0.
- Read addr 0x00020, slave returns 0x12345678 with 3 wait states:
  - penable high 4 cycles, paddr stable throughout.
  - rsp_rdata=0x12345678, rsp_error=0, rsp_valid 6 cycles after accept.
- Read with pslverr=1 alongside pready=1 → rsp_error=1, rsp_timeout=0, rsp_rdata captures prdata.
- pready never asserted, TIMEOUT_CYCLES=8:
  - ACCESS lasts exactly 8 cycles, then rsp_valid with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - psel/penable drop to 0.
- cmd_valid held high with two queued commands (write then read) → second accepted only after the first rsp_valid; cmd_ready low in SETUP/ACCESS/RESP.
- reset_n=0 for one cycle during ACCESS → next cycle psel=penable=0, rsp_valid stays 0, cmd_ready=1; a new command then completes normally.
